rf68000_ring_mem_node: RTL and testbench

//  Ring endpoint for shared resources (global DRAM, I/O, ROM) addressed as device NODE_ID (62).

---
 rtl/rf68000_ring_mem_node.sv | 169 ++++++++++++++++
 tb/tb_rf68000_ring_mem_node.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf68000_ring_mem_node.sv
// rf68000_ring_mem_node: ring endpoint that runs queued requests as master bus cycles and returns responses
package rf68000_ring_pkg;
  typedef enum logic [3:0] {
    PT_NULL, PT_READ, PT_WRITE, PT_AREAD, PT_ACK, PT_AACK, PT_ERR, PT_VPA
  } packet_type_t;
  typedef struct packed {
    logic [5:0] did;
    logic [5:0] sid;
    logic [5:0] age;
    logic ack;
    packet_type_t typ;
    logic [2:0] fc;
    logic [3:0] sel;
    logic [7:0] asid;
    logic mmus;
    logic ios;
    logic iops;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;
endpackage

module rf68000_ring_mem_node import rf68000_ring_pkg::*; #(
  parameter logic [5:0] NODE_ID = 6'd62,
  parameter int REQ_DEPTH = 4,
  parameter bit SYNC_WRITE = 1'b1,
  parameter int TO_BITS = 12
)(
  input  logic clk_i,
  input  logic rst_i,
  input  packet_t packet_i,
  output packet_t packet_o,
  input  packet_t rpacket_i,
  output packet_t rpacket_o,
  output logic m_cyc_o,
  output logic m_stb_o,
  output logic m_we_o,
  output logic [3:0] m_sel_o,
  output logic [2:0] m_fc_o,
  output logic [7:0] m_asid_o,
  output logic m_mmus_o,
  output logic m_ios_o,
  output logic m_iops_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic m_ack_i,
  input  logic m_err_i,
  input  logic m_vpa_i,
  input  logic [31:0] m_dat_i,
  output logic [$clog2(REQ_DEPTH):0] req_cnt_o,
  output logic drop_o
);
  localparam int AW = $clog2(REQ_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, BUS} state_t;
  // Only the fields a bus cycle and its response need are queued.
  typedef struct packed {
    logic [5:0] sid;
    packet_type_t typ;
    logic [2:0] fc;
    logic [3:0] sel;
    logic [7:0] asid;
    logic mmus;
    logic ios;
    logic iops;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;
  state_t state;
  req_t mem [REQ_DEPTH];
  req_t head;
  logic [AW-1:0] wp, rp;
  logic [TO_BITS-1:0] tmo;
  logic [5:0] req_sid;
  packet_type_t req_typ;
  packet_t rsp, rsp_n;
  logic rsp_v, is_req, cap, drop, pop, inj, term;
  assign head = mem[rp];
  assign is_req = packet_i.typ inside {PT_READ, PT_AREAD, PT_WRITE};
  assign cap = packet_i.did == NODE_ID && is_req && req_cnt_o != CW'(REQ_DEPTH);
  assign drop = packet_i.did == NODE_ID && !is_req;
  assign pop = state == IDLE && req_cnt_o != '0 && !rsp_v;
  assign inj = rsp_v && rpacket_i.did == '0;
  assign term = m_ack_i | m_err_i | m_vpa_i | tmo[TO_BITS-1];
  // Bus outputs still hold the request at termination, so the response is built from them.
  always_comb begin
    rsp_n = '0;
    rsp_n.sid = NODE_ID;
    rsp_n.did = req_sid;
    rsp_n.ack = 1'b1;
    rsp_n.typ = m_ack_i ? (req_typ == PT_AREAD ? PT_AACK : PT_ACK) : m_err_i ? PT_ERR : m_vpa_i ? PT_VPA : PT_ERR;
    rsp_n.asid = m_asid_o;
    rsp_n.mmus = m_mmus_o;
    rsp_n.ios = m_ios_o;
    rsp_n.iops = m_iops_o;
    rsp_n.adr = m_adr_o;
    rsp_n.dat = m_dat_i;
  end
  always_ff @(posedge clk_i)
    if (cap) mem[wp] <= '{packet_i.sid, packet_i.typ, packet_i.fc, packet_i.sel, packet_i.asid,
                          packet_i.mmus, packet_i.ios, packet_i.iops, packet_i.adr, packet_i.dat};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      packet_o <= '0;
      rpacket_o <= '0;
      drop_o <= 1'b0;
      wp <= '0;
      rp <= '0;
      req_cnt_o <= '0;
      state <= IDLE;
      tmo <= '0;
      rsp <= '0;
      rsp_v <= 1'b0;
      req_sid <= '0;
      req_typ <= PT_NULL;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o <= 1'b0;
      m_sel_o <= '0;
      m_fc_o <= '0;
      m_asid_o <= '0;
      m_mmus_o <= 1'b0;
      m_ios_o <= 1'b0;
      m_iops_o <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else begin
      packet_o <= packet_i;
      if (cap || drop) packet_o.did <= '0;
      rpacket_o <= inj ? rsp : rpacket_i;
      drop_o <= drop;
      if (cap) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      req_cnt_o <= req_cnt_o + CW'(cap) - CW'(pop);
      if (inj) rsp_v <= 1'b0;
      tmo <= (state == IDLE || term) ? '0 : tmo + TO_BITS'(1);
      if (pop) begin
        state <= BUS;
        req_sid <= head.sid;
        req_typ <= head.typ;
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o <= head.typ == PT_WRITE;
        m_sel_o <= head.sel;
        m_fc_o <= head.fc;
        m_asid_o <= head.asid;
        m_mmus_o <= head.mmus;
        m_ios_o <= head.ios;
        m_iops_o <= head.iops;
        m_adr_o <= head.adr;
        m_dat_o <= head.dat;
      end else if (state == BUS && term) begin
        state <= IDLE;
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o <= 1'b0;
        m_sel_o <= '0;
        m_fc_o <= '0;
        m_mmus_o <= 1'b0;
        m_ios_o <= 1'b0;
        m_iops_o <= 1'b0;
        if (SYNC_WRITE || req_typ != PT_WRITE) begin
          rsp <= rsp_n;
          rsp_v <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rf68000_ring_mem_node.sv
// tb_rf68000_ring_mem_node: directed bench for the ring memory node, synchronous and posted-write variants
module tb_rf68000_ring_mem_node;
  import rf68000_ring_pkg::*;
  logic clk = 1'b0, rst;
  packet_t pkt_i, pkt_o, rpkt_i, rpkt_o;
  logic m_cyc, m_stb, m_we, m_mmus, m_ios, m_iops, m_ack, m_err, m_vpa, drop;
  logic [3:0] m_sel;
  logic [2:0] m_fc;
  logic [7:0] m_asid;
  logic [31:0] m_adr, m_dout, m_din;
  logic [2:0] cnt;
  packet_t p2_i, p2_o, rp2_i, rp2_o;
  logic c2, s2, we2, mm2, io2, iop2, ack2, drop2;
  logic [3:0] sel2;
  logic [2:0] fc2, cnt2;
  logic [7:0] asid2;
  logic [31:0] adr2, dout2, din2;
  int checks = 0, errors = 0, n;

  rf68000_ring_mem_node dut (
    .clk_i(clk), .rst_i(rst), .packet_i(pkt_i), .packet_o(pkt_o), .rpacket_i(rpkt_i), .rpacket_o(rpkt_o),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel), .m_fc_o(m_fc), .m_asid_o(m_asid),
    .m_mmus_o(m_mmus), .m_ios_o(m_ios), .m_iops_o(m_iops), .m_adr_o(m_adr), .m_dat_o(m_dout),
    .m_ack_i(m_ack), .m_err_i(m_err), .m_vpa_i(m_vpa), .m_dat_i(m_din), .req_cnt_o(cnt), .drop_o(drop));

  rf68000_ring_mem_node #(.SYNC_WRITE(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .packet_i(p2_i), .packet_o(p2_o), .rpacket_i(rp2_i), .rpacket_o(rp2_o),
    .m_cyc_o(c2), .m_stb_o(s2), .m_we_o(we2), .m_sel_o(sel2), .m_fc_o(fc2), .m_asid_o(asid2),
    .m_mmus_o(mm2), .m_ios_o(io2), .m_iops_o(iop2), .m_adr_o(adr2), .m_dat_o(dout2),
    .m_ack_i(ack2), .m_err_i(1'b0), .m_vpa_i(1'b0), .m_dat_i(din2), .req_cnt_o(cnt2), .drop_o(drop2));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic packet_t mk(input logic [5:0] did, input logic [5:0] sid, input packet_type_t typ,
                                 input logic [31:0] adr, input logic [31:0] dat);
    mk = '0;
    mk.did = did;
    mk.sid = sid;
    mk.typ = typ;
    mk.adr = adr;
    mk.dat = dat;
    mk.sel = 4'hF;
    mk.fc = 3'd5;
    mk.asid = 8'h11;
    mk.mmus = 1'b1;
  endfunction

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 40 && !m_cyc; i++) tick;
    chk(tag, m_cyc, 1'b1);
  endtask

  task automatic wait_rsp(input string tag, input logic [5:0] did, input packet_type_t typ,
                          input logic [31:0] adr, input logic [31:0] dat);
    for (int i = 0; i < 40 && !rpkt_o.ack; i++) tick;
    chk({tag, "_ack"}, rpkt_o.ack, 1'b1);
    chk({tag, "_did"}, rpkt_o.did, did);
    chk({tag, "_sid"}, rpkt_o.sid, 6'd62);
    chk({tag, "_typ"}, rpkt_o.typ, typ);
    chk({tag, "_adr"}, rpkt_o.adr, adr);
    chk({tag, "_dat"}, rpkt_o.dat, dat);
    chk({tag, "_asid"}, {rpkt_o.asid, rpkt_o.mmus, rpkt_o.fc, rpkt_o.sel}, {8'h11, 1'b1, 3'd0, 4'd0});
  endtask

  // t = {vpa, err, ack}
  task automatic serve(input logic [2:0] t, input logic [31:0] adr, input logic [31:0] d);
    wait_cyc("srv_cyc");
    chk("srv_adr", m_adr, adr);
    {m_vpa, m_err, m_ack} = t;
    m_din = d;
    tick;
    {m_vpa, m_err, m_ack} = 3'b000;
    m_din = '0;
    chk("srv_drop", m_cyc, 1'b0);
  endtask

  initial begin
    pkt_i = '0; rpkt_i = '0; m_ack = 0; m_err = 0; m_vpa = 0; m_din = '0;
    p2_i = '0; rp2_i = '0; ack2 = 0; din2 = '0;
    rst = 1'b1;
    tick; tick;
    chk("rst_pkt", pkt_o, '0);
    chk("rst_rpkt", rpkt_o, '0);
    chk("rst_bus", {m_cyc, m_stb, m_we, m_sel, m_adr}, '0);
    chk("rst_cnt", {cnt, drop}, '0);
    rst = 1'b0;
    // basic read
    pkt_i = mk(62, 3, PT_READ, 32'h40001000, 0);
    tick;
    pkt_i = '0;
    chk("t1_free", pkt_o.did, 6'd0);
    chk("t1_sid", pkt_o.sid, 6'd3);
    chk("t1_cnt", cnt, 3'd1);
    tick;
    chk("t1_cyc", {m_cyc, m_stb, m_we}, 3'b110);
    chk("t1_adr", m_adr, 32'h40001000);
    chk("t1_selfc", {m_sel, m_fc, m_asid, m_mmus}, {4'hF, 3'd5, 8'h11, 1'b1});
    chk("t1_cnt0", cnt, 3'd0);
    tick; tick;
    m_ack = 1'b1; m_din = 32'hDEADBEEF;
    tick;
    m_ack = 1'b0; m_din = '0;
    chk("t1_end", {m_cyc, m_stb, m_sel, m_mmus}, '0);
    chk("t1_noinj", rpkt_o.ack, 1'b0);
    tick;
    chk("t1_inj", rpkt_o.ack, 1'b1);
    wait_rsp("t1", 3, PT_ACK, 32'h40001000, 32'hDEADBEEF);
    tick;
    chk("t1_gone", rpkt_o.ack, 1'b0);
    // FIFO full with the bus stalled
    pkt_i = mk(62, 7, PT_READ, 32'h500, 0);
    tick;
    pkt_i = '0;
    tick;
    chk("t2_busy", m_cyc, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      pkt_i = mk(62, 6'(i), PT_READ, 32'h600 + 32'(4 * i), 0);
      tick;
    end
    pkt_i = '0;
    chk("t2_full", cnt, 3'd4);
    chk("t2_pass", {pkt_o.did, pkt_o.sid}, {6'd62, 6'd5});
    serve(3'b001, 32'h500, 32'hA5A5A5A5);
    wait_rsp("t2a", 7, PT_ACK, 32'h500, 32'hA5A5A5A5);
    tick;
    chk("t2_pop", cnt, 3'd3);
    pkt_i = mk(62, 5, PT_READ, 32'h614, 0);
    tick;
    pkt_i = '0;
    chk("t2_recap", cnt, 3'd4);
    chk("t2_recap_free", pkt_o.did, 6'd0);
    for (int i = 1; i <= 5; i++) begin
      serve(3'b001, 32'h600 + 32'(4 * i), 32'(i));
      wait_rsp("t2q", 6'(i), PT_ACK, 32'h600 + 32'(4 * i), 32'(i));
    end
    // timeout
    pkt_i = mk(62, 9, PT_READ, 32'h100, 0);
    tick;
    pkt_i = '0;
    wait_cyc("t3_cyc");
    n = 0;
    while (m_cyc && n < 3000) begin
      tick;
      n++;
    end
    chk("t3_len", n >= 2048 && n <= 2049, 1'b1);
    wait_rsp("t3", 9, PT_ERR, 32'h100, 0);
    // synchronous write
    pkt_i = mk(62, 4, PT_WRITE, 32'h200, 32'h12345678);
    tick;
    pkt_i = '0;
    wait_cyc("t4_cyc");
    chk("t4_we", m_we, 1'b1);
    chk("t4_dat", m_dout, 32'h12345678);
    serve(3'b001, 32'h200, 0);
    wait_rsp("t4", 4, PT_ACK, 32'h200, 0);
    // posted write on the second node: no response, next request starts
    p2_i = mk(62, 4, PT_WRITE, 32'h210, 32'hCAFE);
    tick;
    p2_i = mk(62, 6, PT_READ, 32'h214, 0);
    tick;
    p2_i = '0;
    chk("t4b_wcyc", {c2, we2}, 2'b11);
    chk("t4b_wadr", {adr2, dout2}, {32'h210, 32'hCAFE});
    ack2 = 1'b1;
    tick;
    ack2 = 1'b0;
    chk("t4b_wend", c2, 1'b0);
    tick;
    chk("t4b_rcyc", {c2, we2}, 2'b10);
    chk("t4b_radr", adr2, 32'h214);
    chk("t4b_norsp", rp2_o.ack, 1'b0);
    ack2 = 1'b1; din2 = 32'h77;
    tick;
    ack2 = 1'b0; din2 = '0;
    tick;
    chk("t4b_rsp", {rp2_o.ack, rp2_o.did, rp2_o.typ, rp2_o.dat}, {1'b1, 6'd6, PT_ACK, 32'h77});
    // response slot busy
    rpkt_i = mk(5, 1, PT_ACK, 0, 0);
    pkt_i = mk(62, 10, PT_READ, 32'h300, 0);
    tick;
    pkt_i = mk(62, 11, PT_READ, 32'h304, 0);
    tick;
    pkt_i = '0;
    serve(3'b001, 32'h300, 32'hBB);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t5_slot", rpkt_o.did, 6'd5);
      chk("t5_hold", m_cyc, 1'b0);
    end
    rpkt_i = '0;
    tick;
    chk("t5_inj", rpkt_o.ack, 1'b1);
    wait_rsp("t5a", 10, PT_ACK, 32'h300, 32'hBB);
    serve(3'b001, 32'h304, 32'hCC);
    wait_rsp("t5b", 11, PT_ACK, 32'h304, 32'hCC);
    // terminations and priority
    pkt_i = mk(62, 12, PT_AREAD, 32'h400, 0);
    tick;
    pkt_i = '0;
    serve(3'b100, 32'h400, 32'h55);
    wait_rsp("t6vpa", 12, PT_VPA, 32'h400, 32'h55);
    pkt_i = mk(62, 13, PT_AREAD, 32'h404, 0);
    tick;
    pkt_i = '0;
    serve(3'b011, 32'h404, 32'h66);
    wait_rsp("t6aack", 13, PT_AACK, 32'h404, 32'h66);
    pkt_i = mk(62, 14, PT_READ, 32'h408, 0);
    tick;
    pkt_i = '0;
    serve(3'b110, 32'h408, 32'h77);
    wait_rsp("t6err", 14, PT_ERR, 32'h408, 32'h77);
    // unsupported type, broadcast, other node
    pkt_i = mk(62, 20, PT_ACK, 32'h500, 0);
    tick;
    pkt_i = '0;
    chk("t6_drop", drop, 1'b1);
    chk("t6_drop_free", pkt_o.did, 6'd0);
    chk("t6_drop_cnt", cnt, 3'd0);
    tick;
    chk("t6_drop_pulse", drop, 1'b0);
    chk("t6_drop_nobus", m_cyc, 1'b0);
    pkt_i = mk(63, 21, PT_READ, 32'h510, 0);
    tick;
    pkt_i = mk(5, 22, PT_READ, 32'h514, 0);
    chk("t6_bcast", {pkt_o.did, cnt, drop}, {6'd63, 3'd0, 1'b0});
    tick;
    pkt_i = '0;
    chk("t6_other", {pkt_o.did, cnt, drop}, {6'd5, 3'd0, 1'b0});
    tick;
    chk("t6_idle", m_cyc, 1'b0);
    // reset during a bus cycle
    pkt_i = mk(62, 30, PT_READ, 32'h700, 0);
    tick;
    pkt_i = mk(62, 31, PT_READ, 32'h704, 0);
    tick;
    pkt_i = '0;
    chk("t7_busy", {m_cyc, cnt}, {1'b1, 3'd1});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t7_rst", {m_cyc, cnt, m_adr}, '0);
    tick; tick;
    chk("t7_quiet", {m_cyc, rpkt_o.ack}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
